// File: rtl/rtc_cmd_parser_pkg.sv
// Shared constants and helpers for the RTC UART command parser.
// Holds the command codes, payload lengths, default frame header, BCD limit
// constants, FSM state encoding and small lookup functions on the command byte.
package rtc_cmd_parser_pkg;

    localparam logic [7:0] HDR_BYTE_DEF = 8'h55;

    localparam logic [7:0] CMD_SET_TIME = 8'h01;
    localparam logic [7:0] CMD_SET_DATE = 8'h02;
    localparam logic [7:0] CMD_READ     = 8'h03;

    localparam logic [2:0] LEN_TIME = 3'd3;
    localparam logic [2:0] LEN_DATE = 3'd4;
    localparam logic [2:0] LEN_READ = 3'd0;

    // BCD field limits (values are BCD-coded bytes)
    localparam logic [3:0] BCD_DIGIT_MAX = 4'd9;
    localparam logic [7:0] HH_MAX = 8'h23;
    localparam logic [7:0] MS_MAX = 8'h59;
    localparam logic [7:0] YY_MAX = 8'h99;
    localparam logic [7:0] MO_MIN = 8'h01;
    localparam logic [7:0] MO_MAX = 8'h12;
    localparam logic [7:0] DD_MIN = 8'h01;
    localparam logic [7:0] DD_MAX = 8'h31;
    localparam logic [7:0] WK_MAX = 8'h06;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_CMD,
        ST_PAYLOAD,
        ST_CHK,
        ST_ISSUE
    } state_e;

    function automatic logic cmd_known(input logic [7:0] cmd);
        return (cmd == CMD_SET_TIME) || (cmd == CMD_SET_DATE) || (cmd == CMD_READ);
    endfunction

    function automatic logic [2:0] cmd_len(input logic [7:0] cmd);
        logic [2:0] len;
        len = LEN_READ;
        if (cmd == CMD_SET_TIME) len = LEN_TIME;
        if (cmd == CMD_SET_DATE) len = LEN_DATE;
        return len;
    endfunction

endpackage

// File: rtl/bcd_range_chk.sv
// Combinational BCD byte range checker.
// Ports:
//   val      in  8  BCD-coded byte under test
//   min_val  in  8  inclusive lower bound (BCD)
//   max_val  in  8  inclusive upper bound (BCD)
//   ok       out 1  both nibbles are decimal digits and min_val <= val <= max_val
module bcd_range_chk
    import rtc_cmd_parser_pkg::*;
(
    input  logic [7:0] val,
    input  logic [7:0] min_val,
    input  logic [7:0] max_val,
    output logic       ok
);

    // For well-formed BCD, binary ordering equals decimal ordering, so the
    // bounds can be compared directly once the digits are known to be legal.
    always_comb begin
        ok = (val[7:4] <= BCD_DIGIT_MAX) && (val[3:0] <= BCD_DIGIT_MAX) &&
             (val >= min_val) && (val <= max_val);
    end

endmodule

// File: rtl/rtc_cmd_parser.sv
// RTC command frame parser.
// Accepts UART frames {HDR_BYTE, CMD, payload, CHK} and turns good frames into
// single-cycle requests for an RTC I2C controller. CHK is the XOR of CMD and
// all payload bytes; payload fields are range-checked as BCD before issue.
// Ports:
//   clk         in  1   system clock
//   rstn        in  1   asynchronous active-low reset
//   rx_data     in  8   received byte, valid with rx_done
//   rx_done     in  1   one-cycle strobe per received byte
//   ctrl_busy   in  1   controller busy; requests are held off while high
//   wr_time_en  out 1   one-cycle request to write time_wdata
//   wr_date_en  out 1   one-cycle request to write date_wdata
//   rd_en       out 1   one-cycle request to read time and date
//   time_wdata  out 24  BCD {hh,mm,ss}
//   date_wdata  out 32  BCD {yy,mo,dd,wk}
//   frame_err   out 1   one-cycle pulse on a rejected frame
module rtc_cmd_parser
    import rtc_cmd_parser_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYC = 5_000_000,
    parameter logic [7:0]  HDR_BYTE    = HDR_BYTE_DEF
) (
    input  logic        clk,
    input  logic        rstn,
    input  logic [7:0]  rx_data,
    input  logic        rx_done,
    input  logic        ctrl_busy,
    output logic        wr_time_en,
    output logic        wr_date_en,
    output logic        rd_en,
    output logic [23:0] time_wdata,
    output logic [31:0] date_wdata,
    output logic        frame_err
);

    localparam int unsigned CNT_W = $clog2(TIMEOUT_CYC + 1);
    localparam logic [CNT_W-1:0] TMO_LAST = CNT_W'(TIMEOUT_CYC - 1);

    state_e            state_q, state_d;
    logic [7:0]        cmd_q, cmd_d;
    logic [7:0]        chk_acc_q, chk_acc_d;
    logic [7:0]        chk_byte_q, chk_byte_d;
    logic              chk_got_q, chk_got_d;
    logic [2:0]        pay_cnt_q, pay_cnt_d;
    logic [31:0]       staging_q, staging_d;
    logic [CNT_W-1:0]  tmo_cnt_q, tmo_cnt_d;
    logic              frame_err_q, frame_err_d;
    logic [23:0]       time_wdata_q, time_wdata_d;
    logic [31:0]       date_wdata_q, date_wdata_d;

    logic              tmo_expired;
    logic              frame_good;
    logic [3:0]        lane_ok;
    logic [3:0][7:0]   lane_min, lane_max;

    // ------------------------------------------------------------------
    // Payload range checking: one checker per staging byte, bounds chosen
    // by the command. Unused lanes are bounded 00..00; staging is cleared
    // at frame start so a short (time) payload leaves lane 3 at zero.
    // ------------------------------------------------------------------
    always_comb begin
        lane_min = '0;
        lane_max = '0;
        if (cmd_q == CMD_SET_TIME) begin
            lane_max[2] = HH_MAX;
            lane_max[1] = MS_MAX;
            lane_max[0] = MS_MAX;
        end else if (cmd_q == CMD_SET_DATE) begin
            lane_max[3] = YY_MAX;
            lane_min[2] = MO_MIN;
            lane_max[2] = MO_MAX;
            lane_min[1] = DD_MIN;
            lane_max[1] = DD_MAX;
            lane_max[0] = WK_MAX;
        end
    end

    for (genvar i = 0; i < 4; i++) begin : g_lane
        bcd_range_chk u_chk (
            .val     (staging_q[8*i +: 8]),
            .min_val (lane_min[i]),
            .max_val (lane_max[i]),
            .ok      (lane_ok[i])
        );
    end

    // Checksum byte and payload are both registered, so the verdict is
    // formed one cycle after the CHK byte arrives.
    assign frame_good  = (chk_byte_q == chk_acc_q) &&
                         ((cmd_q == CMD_READ) || (&lane_ok));
    assign tmo_expired = (tmo_cnt_q == TMO_LAST);

    // ------------------------------------------------------------------
    // State register
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q      <= ST_IDLE;
            cmd_q        <= '0;
            chk_acc_q    <= '0;
            chk_byte_q   <= '0;
            chk_got_q    <= 1'b0;
            pay_cnt_q    <= '0;
            staging_q    <= '0;
            tmo_cnt_q    <= '0;
            frame_err_q  <= 1'b0;
            time_wdata_q <= 24'h000000;
            date_wdata_q <= 32'h00010100;
        end else begin
            state_q      <= state_d;
            cmd_q        <= cmd_d;
            chk_acc_q    <= chk_acc_d;
            chk_byte_q   <= chk_byte_d;
            chk_got_q    <= chk_got_d;
            pay_cnt_q    <= pay_cnt_d;
            staging_q    <= staging_d;
            tmo_cnt_q    <= tmo_cnt_d;
            frame_err_q  <= frame_err_d;
            time_wdata_q <= time_wdata_d;
            date_wdata_q <= date_wdata_d;
        end
    end

    // ------------------------------------------------------------------
    // Next-state / datapath
    // ------------------------------------------------------------------
    always_comb begin
        state_d      = state_q;
        cmd_d        = cmd_q;
        chk_acc_d    = chk_acc_q;
        chk_byte_d   = chk_byte_q;
        chk_got_d    = chk_got_q;
        pay_cnt_d    = pay_cnt_q;
        staging_d    = staging_q;
        tmo_cnt_d    = '0;
        frame_err_d  = 1'b0;
        time_wdata_d = time_wdata_q;
        date_wdata_d = date_wdata_q;

        unique case (state_q)
            ST_IDLE: begin
                // Anything but the header is silently discarded here.
                if (rx_done && (rx_data == HDR_BYTE)) state_d = ST_CMD;
            end

            ST_CMD: begin
                if (rx_done) begin
                    cmd_d     = rx_data;
                    chk_acc_d = rx_data;
                    staging_d = '0;
                    pay_cnt_d = '0;
                    chk_got_d = 1'b0;
                    if (!cmd_known(rx_data)) begin
                        frame_err_d = 1'b1;
                        state_d     = ST_IDLE;
                    end else if (cmd_len(rx_data) == 3'd0) begin
                        state_d = ST_CHK;
                    end else begin
                        state_d = ST_PAYLOAD;
                    end
                end else if (tmo_expired) begin
                    frame_err_d = 1'b1;
                    state_d     = ST_IDLE;
                end else begin
                    tmo_cnt_d = tmo_cnt_q + CNT_W'(1);
                end
            end

            ST_PAYLOAD: begin
                if (rx_done) begin
                    staging_d = {staging_q[23:0], rx_data};
                    chk_acc_d = chk_acc_q ^ rx_data;
                    if (pay_cnt_q == cmd_len(cmd_q) - 3'd1) begin
                        pay_cnt_d = '0;
                        state_d   = ST_CHK;
                    end else begin
                        pay_cnt_d = pay_cnt_q + 3'd1;
                    end
                end else if (tmo_expired) begin
                    frame_err_d = 1'b1;
                    state_d     = ST_IDLE;
                end else begin
                    tmo_cnt_d = tmo_cnt_q + CNT_W'(1);
                end
            end

            ST_CHK: begin
                if (chk_got_q) begin
                    // Verdict cycle: bytes arriving now are dropped.
                    chk_got_d = 1'b0;
                    if (frame_good) begin
                        state_d = ST_ISSUE;
                        if (cmd_q == CMD_SET_TIME) time_wdata_d = staging_q[23:0];
                        if (cmd_q == CMD_SET_DATE) date_wdata_d = staging_q;
                    end else begin
                        frame_err_d = 1'b1;
                        state_d     = ST_IDLE;
                    end
                end else if (rx_done) begin
                    chk_byte_d = rx_data;
                    chk_got_d  = 1'b1;
                end else if (tmo_expired) begin
                    frame_err_d = 1'b1;
                    state_d     = ST_IDLE;
                end else begin
                    tmo_cnt_d = tmo_cnt_q + CNT_W'(1);
                end
            end

            ST_ISSUE: begin
                // Unbounded wait on the controller; rx bytes are ignored.
                if (!ctrl_busy) state_d = ST_IDLE;
            end

            default: state_d = ST_IDLE;
        endcase
    end

    // ------------------------------------------------------------------
    // Outputs: the request fires in the very cycle busy is seen low.
    // ------------------------------------------------------------------
    always_comb begin
        wr_time_en = 1'b0;
        wr_date_en = 1'b0;
        rd_en      = 1'b0;
        if ((state_q == ST_ISSUE) && !ctrl_busy) begin
            if (cmd_q == CMD_SET_TIME)      wr_time_en = 1'b1;
            else if (cmd_q == CMD_SET_DATE) wr_date_en = 1'b1;
            else                            rd_en      = 1'b1;
        end
    end

    assign frame_err  = frame_err_q;
    assign time_wdata = time_wdata_q;
    assign date_wdata = date_wdata_q;

endmodule

// File: tb/tb_rtc_cmd_parser.sv
// Scoreboard bench for rtc_cmd_parser: stimulus pushes expected pulses into a
// queue, a negedge monitor pops and compares whenever a pulse appears.
// CHK bytes below are the XOR of CMD and payload bytes.
module tb_rtc_cmd_parser;

    localparam int unsigned TMO = 200;
    localparam int K_TIME = 0, K_DATE = 1, K_RD = 2, K_ERR = 3;

    typedef struct {
        int          kind;
        logic [23:0] t;
        logic [31:0] d;
        int          cyc;   // -1: cycle not checked
    } exp_t;

    logic        clk = 1'b0;
    logic        rstn;
    logic [7:0]  rx_data;
    logic        rx_done;
    logic        ctrl_busy;
    logic        wr_time_en, wr_date_en, rd_en, frame_err;
    logic [23:0] time_wdata;
    logic [31:0] date_wdata;

    exp_t q[$];
    int   n_pass  = 0;
    int   n_total = 0;
    int   cyc     = 0;
    int   last_cyc;

    rtc_cmd_parser #(.TIMEOUT_CYC(TMO), .HDR_BYTE(8'h55)) dut (
        .clk        (clk),
        .rstn       (rstn),
        .rx_data    (rx_data),
        .rx_done    (rx_done),
        .ctrl_busy  (ctrl_busy),
        .wr_time_en (wr_time_en),
        .wr_date_en (wr_date_en),
        .rd_en      (rd_en),
        .time_wdata (time_wdata),
        .date_wdata (date_wdata),
        .frame_err  (frame_err)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    endtask

    // Called at #1 after a posedge; leaves at #1 after the next posedge.
    task automatic send_byte(input logic [7:0] b);
        rx_data  = b;
        rx_done  = 1'b1;
        last_cyc = cyc;
        @(posedge clk); #1;
        rx_done  = 1'b0;
    endtask

    // Sends n bytes from a packed vector, most significant byte first.
    task automatic send_frame(input int n, input logic [63:0] bytes);
        for (int i = 0; i < n; i++) send_byte(bytes[8*(n-1-i) +: 8]);
    endtask

    task automatic push(input int kind, input logic [23:0] t, input logic [31:0] d, input int c);
        exp_t e;
        e.kind = kind; e.t = t; e.d = d; e.cyc = c;
        q.push_back(e);
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Monitor: every asserted pulse must match the head of the queue.
    always @(negedge clk) begin : mon
        int   n;
        int   k;
        exp_t e;
        if (rstn === 1'b1) begin
            n = int'(wr_time_en) + int'(wr_date_en) + int'(rd_en) + int'(frame_err);
            if (n != 0) begin
                chk("pulse_onehot", n, 1);
                k = wr_time_en ? K_TIME : wr_date_en ? K_DATE : rd_en ? K_RD : K_ERR;
                chk("pulse_expected", q.size() > 0, 1);
                if (q.size() > 0) begin
                    e = q.pop_front();
                    chk("pulse_kind", k, e.kind);
                    if (e.kind == K_TIME) chk("time_wdata_at_pulse", time_wdata, e.t);
                    if (e.kind == K_DATE) chk("date_wdata_at_pulse", date_wdata, e.d);
                    if (e.cyc >= 0)       chk("pulse_cycle", cyc, e.cyc);
                end
            end
        end
    end

    initial begin
        rstn = 1'b0; rx_data = 8'h00; rx_done = 1'b0; ctrl_busy = 1'b0;
        idle(2);
        chk("rst_time_wdata", time_wdata, 24'h000000);
        chk("rst_date_wdata", date_wdata, 32'h00010100);
        chk("rst_pulses", {wr_time_en, wr_date_en, rd_en, frame_err}, 4'b0000);
        rstn = 1'b1;
        idle(2);

        // Non-header bytes in IDLE are ignored without error.
        send_frame(3, 24'h00_AA_13);
        idle(3);

        // Set time.
        send_frame(6, 48'h55_01_12_34_56_71);
        push(K_TIME, 24'h123456, 32'h0, last_cyc + 2);
        idle(5);
        chk("time_hold", time_wdata, 24'h123456);

        // Set date.
        send_frame(7, 56'h55_02_24_06_15_03_36);
        push(K_DATE, 24'h0, 32'h24061503, last_cyc + 2);
        idle(5);
        chk("date_hold", date_wdata, 32'h24061503);

        // Hour 25 out of range, checksum correct.
        send_frame(6, 48'h55_01_25_00_00_24);
        push(K_ERR, 24'h0, 32'h0, -1);
        idle(5);
        chk("time_unchanged_range", time_wdata, 24'h123456);

        // Checksum mismatch (correct would be 8'h10).
        send_frame(6, 48'h55_01_11_11_11_00);
        push(K_ERR, 24'h0, 32'h0, -1);
        idle(5);
        chk("time_unchanged_chk", time_wdata, 24'h123456);

        // Unknown command.
        send_frame(2, 16'h55_09);
        push(K_ERR, 24'h0, 32'h0, -1);
        idle(5);

        // Header value inside the payload is plain data (yy=55).
        send_frame(7, 56'h55_02_55_01_01_00_57);
        push(K_DATE, 24'h0, 32'h55010100, last_cyc + 2);
        idle(5);

        // Read with controller busy for 40 cycles; a full frame sent while
        // waiting must be dropped.
        ctrl_busy = 1'b1;
        send_frame(3, 24'h55_03_03);
        send_frame(6, 48'h55_01_12_34_56_71);
        idle(31);
        ctrl_busy = 1'b0;
        push(K_RD, 24'h0, 32'h0, cyc);
        idle(5);
        chk("time_unchanged_drop", time_wdata, 24'h123456);

        // Inter-byte timeout, then a good frame.
        send_frame(3, 24'h55_01_12);
        push(K_ERR, 24'h0, 32'h0, -1);
        idle(TMO + 10);
        chk("time_unchanged_tmo", time_wdata, 24'h123456);
        send_frame(6, 48'h55_01_23_59_59_22);
        push(K_TIME, 24'h235959, 32'h0, last_cyc + 2);
        idle(5);
        chk("time_after_tmo", time_wdata, 24'h235959);

        // Reset in mid-frame, then a good frame.
        send_frame(3, 24'h55_01_12);
        rstn = 1'b0;
        #1;
        chk("midrst_time_wdata", time_wdata, 24'h000000);
        chk("midrst_date_wdata", date_wdata, 32'h00010100);
        chk("midrst_pulses", {wr_time_en, wr_date_en, rd_en, frame_err}, 4'b0000);
        idle(2);
        rstn = 1'b1;
        idle(2);
        send_frame(6, 48'h55_01_08_30_00_39);
        push(K_TIME, 24'h083000, 32'h0, last_cyc + 2);
        idle(5);
        chk("time_after_rst", time_wdata, 24'h083000);

        idle(5);
        chk("all_expected_seen", q.size(), 0);
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, expected end of stimulus");
        n_total++;
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
